softmax_frame_sequencer: RTL

- Controller that sequences the softmax/max-index unit at the classifier output of the CNN.
- Collects one frame of NUM_CLASSES class scores (IEEE-754 single precision) serially from the fully-connected stage over a valid/ready stream, and holds them stable on the unit's parallel input.
- Restarts the unit with a synchronous clear, waits for its done flag with a timeout, captures the max value and index, and presents them on a valid/ready result port.
- Frames are processed one at a time.

---
 rtl/softmax_frame_sequencer_if.sv | 26 ++
 rtl/softmax_frame_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/softmax_frame_sequencer_if.sv
// Score stream (s_*) and result (r_*) handshakes of the softmax frame sequencer.
// master = score producer / result consumer, slave = sequencer.
interface softmax_frame_sequencer_if #(
    parameter int unsigned DATAWIDTH = 32
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATAWIDTH-1:0] s_data;
    logic                 s_last;

    logic                 r_valid;
    logic                 r_ready;
    logic [DATAWIDTH-1:0] r_max;
    logic [3:0]           r_index;
    logic                 r_error;

    modport master (
        output s_valid, s_data, s_last, r_ready,
        input  s_ready, r_valid, r_max, r_index, r_error
    );

    modport slave (
        input  s_valid, s_data, s_last, r_ready,
        output s_ready, r_valid, r_max, r_index, r_error
    );
endinterface

// File: rtl/softmax_frame_sequencer.sv
// Collects one frame of class scores, restarts the softmax unit, waits for done
// (with timeout) and presents the captured max/index on a result handshake.
module softmax_frame_sequencer #(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned NUM_CLASSES  = 10,
    parameter int unsigned CLEAR_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                             clock,
    input  logic                             reset,
    softmax_frame_sequencer_if.slave         bus,
    output logic [NUM_CLASSES*DATAWIDTH-1:0] sm_scores,
    output logic                             sm_reset,
    input  logic                             sm_done,
    input  logic [DATAWIDTH-1:0]             sm_max,
    input  logic [3:0]                       sm_index,
    output logic                             busy,
    output logic [15:0]                      frame_count
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO_W = 16;

    localparam logic [DATAWIDTH-1:0] NEG_INF   = DATAWIDTH'(32'hFF80_0000);
    localparam logic [CNT_W-1:0]     LAST_SLOT = CNT_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0]     CLR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CLEAR  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     clr_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 err_flag;
    logic                 s_ready_q;
    logic                 r_valid_q;
    logic [DATAWIDTH-1:0] r_max_q;
    logic [3:0]           r_index_q;
    logic                 r_error_q;

    logic accept;
    logic frame_end;
    logic take_done;
    logic take_tmo;
    logic handshake;

    assign bus.s_ready = s_ready_q;
    assign bus.r_valid = r_valid_q;
    assign bus.r_max   = r_max_q;
    assign bus.r_index = r_index_q;
    assign bus.r_error = r_error_q;

    // Unit is held in reset together with the sequencer, not one cycle later.
    assign sm_reset = reset | (state == CLEAR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        frame_end = 1'b0;
        take_done = 1'b0;
        take_tmo  = 1'b0;
        handshake = 1'b0;
        case (state)
            LOAD: begin
                accept    = bus.s_valid & s_ready_q;
                frame_end = accept & (bus.s_last | (cnt == LAST_SLOT));
                if (frame_end) state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) state_d = WAIT;
            end
            WAIT: begin
                // First WAIT cycle ignores done; done beats a coinciding timeout.
                if ((tmo_cnt != '0) && sm_done) begin
                    take_done = 1'b1;
                    state_d   = RESULT;
                end else if (tmo_cnt == TMO_LAST) begin
                    take_tmo = 1'b1;
                    state_d  = RESULT;
                end
            end
            RESULT: begin
                handshake = bus.r_ready;
                if (handshake) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            clr_cnt     <= '0;
            tmo_cnt     <= '0;
            err_flag    <= 1'b0;
            sm_scores   <= '0;
            s_ready_q   <= 1'b1;
            busy        <= 1'b0;
            r_valid_q   <= 1'b0;
            r_max_q     <= '0;
            r_index_q   <= '0;
            r_error_q   <= 1'b0;
            frame_count <= '0;
        end else begin
            s_ready_q <= (state_d == LOAD);
            busy      <= (state_d != LOAD);

            // An early s_last pads the untouched slots with -inf on the same edge.
            if (accept) begin
                for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                    if (CNT_W'(i) == cnt) begin
                        sm_scores[i*DATAWIDTH +: DATAWIDTH] <= bus.s_data;
                    end else if (bus.s_last && (CNT_W'(i) > cnt)) begin
                        sm_scores[i*DATAWIDTH +: DATAWIDTH] <= NEG_INF;
                    end
                end
                cnt <= frame_end ? '0 : cnt + CNT_W'(1);
                if (frame_end && !((cnt == LAST_SLOT) && bus.s_last)) begin
                    err_flag <= 1'b1;
                end
            end

            if (state == CLEAR) begin
                clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + CNT_W'(1);
            end

            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (take_done) begin
                r_valid_q <= 1'b1;
                r_max_q   <= sm_max;
                r_index_q <= sm_index;
                r_error_q <= err_flag;
            end else if (take_tmo) begin
                r_valid_q <= 1'b1;
                r_max_q   <= '0;
                r_index_q <= 4'hF;
                r_error_q <= 1'b1;
            end

            if (handshake) begin
                r_valid_q   <= 1'b0;
                frame_count <= frame_count + 16'd1;
                err_flag    <= 1'b0;
                tmo_cnt     <= '0;
            end
        end
    end
endmodule
